writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries; power of two, minimum 2.
REQ-002 Parameter DATA_W, 32, result data width.
REQ-003 Parameter ADDR_W, 3, register index width; 8 registers.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 alu_valid  in  1  ALU result offered.
REQ-007 alu_dest  in  ADDR_W  ALU destination register.
REQ-008 alu_data  in  DATA_W  ALU result value.
REQ-009 alu_ready  out  1  ALU result accepted this cycle when high with alu_valid.
REQ-010 mem_valid  in  1  load result offered.
REQ-011 mem_dest  in  ADDR_W  load destination register.
REQ-012 mem_data  in  DATA_W  load result value.
REQ-013 mem_ready  out  1  load result accepted this cycle when high with mem_valid.
REQ-014 rf_write_enable  out  1  register-file write strobe.
REQ-015 rf_dest  out  ADDR_W  register-file write index.
REQ-016 rf_data  out  DATA_W  register-file write data.
REQ-017 pending_mask  out  8  bit i high while any queued entry targets register i.
REQ-018 count  out  log2(DEPTH)+1  number of queued entries.

Function
REQ-019 Block SHALL buffer results in an in-order FIFO and drain one entry per cycle into the register file's single write port.
REQ-020 mem_ready SHALL equal !full && !rst.
REQ-021 alu_ready SHALL equal !full && !mem_valid && !rst; load has fixed priority.
REQ-022 At most one enqueue per cycle; a transfer occurs on a rising edge where valid && ready.
REQ-023 Full SHALL be count==DEPTH; ready SHALL not depend on same-cycle drain (no push-through when full).
REQ-024 rf_write_enable SHALL equal count!=0; rf_dest/rf_data SHALL be the head entry, driven 0 when empty.
REQ-025 Head entry SHALL pop on every rising edge where rf_write_enable is high; the register file captures it on that edge.
REQ-026 Latency: entry accepted at edge N into empty queue is written at edge N+1.
REQ-027 Simultaneous enqueue and dequeue SHALL leave count unchanged; read/write pointers wrap modulo DEPTH.
REQ-028 pending_mask SHALL be combinational OR of one-hot(dest) over valid entries; same register in multiple entries keeps its bit set until the last pops.
REQ-029 Writes to one register SHALL retire in acceptance order (WAW preserved).
REQ-030 No special handling of register 0; it is an ordinary register.

Reset
REQ-031 rst SHALL immediately clear count, pointers and entry valid state; rf_write_enable=0, rf_dest=0, rf_data=0, pending_mask=0, count=0, alu_ready=0, mem_ready=0 while asserted.
REQ-032 Reset mid-operation SHALL discard all queued entries with no register-file write.
REQ-033 First enqueue SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-034 Package wb_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS=8 constants and wb_entry_t typedef {dest, data}.
REQ-035 One sub-module wb_fifo (parameterised DEPTH, entry-wide, push/pop/full/empty/count) SHALL hold storage; arbitration and pending_mask live in writeback_queue.

Verification
REQ-036 ALU result dest=3 data=0xDEADBEEF into empty queue -> rf_write_enable, rf_dest=3, rf_data=0xDEADBEEF next cycle; pending_mask=0x08 for that cycle only.
REQ-037 alu_valid and mem_valid same cycle (alu dest=1, mem dest=2) -> mem accepted, alu_ready=0; alu accepted next cycle; writes retire dest 2 then 1.
REQ-038 Five back-to-back mem results with no drain stall -> count never exceeds DEPTH=4, mem_ready drops when count=4, all five written in order.
REQ-039 Two writes to dest=5 (0x1 then 0x2) -> pending_mask bit 5 stays high until second pops; final register 5 = 0x2.
REQ-040 rst asserted with count=3 -> count=0, rf_write_enable=0, readies=0 immediately; no further writes after deassert until new input.
REQ-041 Continuous one-per-cycle ALU stream for 20 cycles -> count steady at 1, pointers wrap, all 20 written in order.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and the queued entry type for the writeback queue.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    // One pending register-file write: destination index and result value.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// In-order circular FIFO holding writeback entries.
// Push is ignored when full and pop is ignored when empty. Per-slot valid
// bits and the raw slot contents are exported so the owner can summarise
// which registers have writes in flight.
module wb_fifo #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 35
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_push,
    input  logic [ENTRY_W-1:0]            i_push_data,
    input  logic                          i_pop,
    output logic [ENTRY_W-1:0]            o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic [DEPTH*ENTRY_W-1:0]      o_entries,
    output logic [DEPTH-1:0]              o_valid
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [DEPTH-1:0]   r_valid;

    logic               w_do_push;
    logic               w_do_pop;
    logic [DEPTH-1:0]   w_set_mask;
    logic [DEPTH-1:0]   w_clr_mask;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign w_set_mask = w_do_push ? (DEPTH'(1) << r_wr_ptr) : '0;
    assign w_clr_mask = w_do_pop  ? (DEPTH'(1) << r_rd_ptr) : '0;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_valid = r_valid;

    // Flatten storage so the owner can scan every slot.
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_entries[g*ENTRY_W +: ENTRY_W] = r_mem[g];
    end

    // Entry storage; contents are only meaningful where r_valid is set.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and slot valid bits; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_valid <= (r_valid & ~w_clr_mask) | w_set_mask;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue: arbitrates ALU and load results into one in-order FIFO
// and drains the head into the single register-file write port each cycle.
//
// Handshake: a result transfers on a rising edge where valid && ready.
// Readiness depends only on fullness (never on the same-cycle drain) and
// is held low during reset; loads win over ALU results when both offer.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [ADDR_W-1:0]      mem_dest,
    input  logic [DATA_W-1:0]      mem_data,
    output logic                   mem_ready,
    output logic                   rf_write_enable,
    output logic [ADDR_W-1:0]      rf_dest,
    output logic [DATA_W-1:0]      rf_data,
    output logic [7:0]             pending_mask,
    output logic [$clog2(DEPTH):0] count
);

    import wb_pkg::*;

    logic                        w_full;
    logic                        w_empty;
    logic                        w_push;
    logic                        w_pop;
    wb_entry_t                   w_push_entry;
    wb_entry_t                   w_head;
    logic [DEPTH*ENTRY_W-1:0]    w_entries;
    logic [DEPTH-1:0]            w_valid;
    logic [NUM_REGS-1:0]         w_mask;

    // Readiness: fullness only, suppressed while reset is asserted.
    assign mem_ready = !w_full && !rst;
    assign alu_ready = !w_full && !mem_valid && !rst;

    assign w_push = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign w_pop  = !w_empty;

    // Select the winning source; loads have fixed priority.
    always_comb begin
        w_push_entry = '0;
        if (mem_valid) begin
            w_push_entry.dest = mem_dest;
            w_push_entry.data = mem_data;
        end else begin
            w_push_entry.dest = alu_dest;
            w_push_entry.data = alu_data;
        end
    end

    wb_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count),
        .o_entries   (w_entries),
        .o_valid     (w_valid)
    );

    // The head is written whenever anything is queued; zeros when empty.
    assign rf_write_enable = !w_empty;
    assign rf_dest         = w_empty ? '0 : w_head.dest;
    assign rf_data         = w_empty ? '0 : w_head.data;

    // Registers with a write in flight: OR of one-hot dest over live slots.
    always_comb begin
        wb_entry_t v_slot;
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v_slot = w_entries[i*ENTRY_W +: ENTRY_W];
            if (w_valid[i]) begin
                w_mask[v_slot.dest] = 1'b1;
            end
        end
    end

    assign pending_mask = w_mask;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: each scenario task drives inputs just
// after a rising edge and checks outputs before the next one; a negedge
// monitor records every register-file write for ordering checks.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int EW     = ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_dest;
    logic [DATA_W-1:0] rf_data;
    logic [7:0]        pending_mask;
    logic [2:0]        count;

    logic [EW-1:0]     wr_log[$];
    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] rf_model[8];

    int total;
    int bad;

    writeback_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_dest        (alu_dest),
        .alu_data        (alu_data),
        .alu_ready       (alu_ready),
        .mem_valid       (mem_valid),
        .mem_dest        (mem_dest),
        .mem_data        (mem_data),
        .mem_ready       (mem_ready),
        .rf_write_enable (rf_write_enable),
        .rf_dest         (rf_dest),
        .rf_data         (rf_data),
        .pending_mask    (pending_mask),
        .count           (count)
    );

    // Clock and safety net.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register-file model: a write seen at negedge commits on the next posedge.
    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) begin
            wr_log.push_back({rf_dest, rf_data});
            rf_model[rf_dest] = rf_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_dest  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_dest  = '0;
        mem_data  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 8; i++) rf_model[i] = '0;
        #2;
        total++;
        if (count !== 3'd0 || rf_write_enable !== 1'b0 || pending_mask !== 8'h00) begin
            $display("FAIL reset_state cnt=%0d we=%b mask=%h exp 0/0/00", count, rf_write_enable, pending_mask);
            bad++;
        end
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || rf_dest !== '0 || rf_data !== '0) begin
            $display("FAIL reset_ready alu_rdy=%b mem_rdy=%b dest=%0d data=%h exp 0", alu_ready, mem_ready, rf_dest, rf_data);
            bad++;
        end
        step();
        step();
        rst = 1'b0;
        #1;
        total++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            $display("FAIL post_reset_ready alu_rdy=%b mem_rdy=%b exp 1/1", alu_ready, mem_ready);
            bad++;
        end
        wr_log.delete();
    endtask

    task automatic test_single();
        wr_log.delete();
        exp_q.delete();
        exp_q.push_back({3'd3, 32'hDEADBEEF});
        alu_valid = 1'b1;
        alu_dest  = 3'd3;
        alu_data  = 32'hDEADBEEF;
        #1;
        total++;
        if (alu_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
            $display("FAIL single_accept alu_rdy=%b we=%b exp 1/0", alu_ready, rf_write_enable);
            bad++;
        end
        step();
        alu_valid = 1'b0;
        #1;
        total++;
        if (rf_write_enable !== 1'b1 || rf_dest !== 3'd3 || rf_data !== 32'hDEADBEEF) begin
            $display("FAIL single_write we=%b dest=%0d data=%h exp 1/3/deadbeef", rf_write_enable, rf_dest, rf_data);
            bad++;
        end
        total++;
        if (pending_mask !== 8'h08 || count !== 3'd1) begin
            $display("FAIL single_mask mask=%h cnt=%0d exp 08/1", pending_mask, count);
            bad++;
        end
        step();
        total++;
        if (pending_mask !== 8'h00 || count !== 3'd0 || rf_write_enable !== 1'b0 || rf_data !== '0) begin
            $display("FAIL single_drained mask=%h cnt=%0d we=%b data=%h exp 00/0/0/0", pending_mask, count, rf_write_enable, rf_data);
            bad++;
        end
        step();
        total++;
        if (wr_log.size() != exp_q.size() || wr_log[0] !== exp_q[0]) begin
            $display("FAIL single_log n=%0d first=%h exp n=%0d first=%h", wr_log.size(), wr_log[0], exp_q.size(), exp_q[0]);
            bad++;
        end
    endtask

    task automatic test_priority();
        wr_log.delete();
        exp_q.delete();
        exp_q.push_back({3'd2, 32'h0000_0022});
        exp_q.push_back({3'd1, 32'h0000_0011});
        alu_valid = 1'b1;
        alu_dest  = 3'd1;
        alu_data  = 32'h0000_0011;
        mem_valid = 1'b1;
        mem_dest  = 3'd2;
        mem_data  = 32'h0000_0022;
        #1;
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            $display("FAIL prio_ready alu_rdy=%b mem_rdy=%b exp 0/1", alu_ready, mem_ready);
            bad++;
        end
        step();
        mem_valid = 1'b0;
        #1;
        total++;
        if (alu_ready !== 1'b1 || count !== 3'd1 || rf_dest !== 3'd2) begin
            $display("FAIL prio_mem_first alu_rdy=%b cnt=%0d dest=%0d exp 1/1/2", alu_ready, count, rf_dest);
            bad++;
        end
        step();
        alu_valid = 1'b0;
        #1;
        total++;
        if (count !== 3'd1 || rf_dest !== 3'd1 || pending_mask !== 8'h02) begin
            $display("FAIL prio_alu_second cnt=%0d dest=%0d mask=%h exp 1/1/02", count, rf_dest, pending_mask);
            bad++;
        end
        step();
        step();
        total++;
        if (wr_log.size() != exp_q.size()) begin
            $display("FAIL prio_log_len got=%0d exp=%0d", wr_log.size(), exp_q.size());
            bad++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (wr_log[i] !== exp_q[i]) begin
                    $display("FAIL prio_order idx=%0d got=%h exp=%h", i, wr_log[i], exp_q[i]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_log.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1'b1;
            mem_dest  = 3'(i + 2);
            mem_data  = 32'hA000_0000 + 32'(i);
            exp_q.push_back({3'(i + 2), 32'hA000_0000 + 32'(i)});
            #1;
            total++;
            if (mem_ready !== 1'b1 || count !== ((i == 0) ? 3'd0 : 3'd1)) begin
                $display("FAIL b2b_step i=%0d mem_rdy=%b cnt=%0d exp 1/%0d", i, mem_ready, count, (i == 0) ? 0 : 1);
                bad++;
            end
            step();
        end
        mem_valid = 1'b0;
        step();
        step();
        total++;
        if (count !== 3'd0 || wr_log.size() != exp_q.size()) begin
            $display("FAIL b2b_drain cnt=%0d n=%0d exp 0/%0d", count, wr_log.size(), exp_q.size());
            bad++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (wr_log[i] !== exp_q[i]) begin
                    $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, wr_log[i], exp_q[i]);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_waw();
        wr_log.delete();
        exp_q.delete();
        exp_q.push_back({3'd5, 32'h1});
        exp_q.push_back({3'd5, 32'h2});
        mem_valid = 1'b1;
        mem_dest  = 3'd5;
        mem_data  = 32'h1;
        step();
        mem_data  = 32'h2;
        #1;
        total++;
        if (pending_mask !== 8'h20 || count !== 3'd1 || rf_data !== 32'h1) begin
            $display("FAIL waw_first mask=%h cnt=%0d data=%h exp 20/1/1", pending_mask, count, rf_data);
            bad++;
        end
        step();
        mem_valid = 1'b0;
        #1;
        total++;
        if (pending_mask !== 8'h20 || rf_data !== 32'h2) begin
            $display("FAIL waw_second mask=%h data=%h exp 20/2", pending_mask, rf_data);
            bad++;
        end
        step();
        total++;
        if (pending_mask !== 8'h00) begin
            $display("FAIL waw_clear mask=%h exp 00", pending_mask);
            bad++;
        end
        step();
        total++;
        if (rf_model[5] !== 32'h2 || wr_log.size() != 2 || wr_log[0] !== exp_q[0] || wr_log[1] !== exp_q[1]) begin
            $display("FAIL waw_final reg5=%h n=%0d exp 2/2", rf_model[5], wr_log.size());
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1;
        alu_dest  = 3'd6;
        alu_data  = 32'h0000_0066;
        step();
        mem_valid = 1'b1;
        mem_dest  = 3'd7;
        mem_data  = 32'h0000_0077;
        rst = 1'b1;
        #1;
        wr_log.delete();
        total++;
        if (count !== 3'd0 || rf_write_enable !== 1'b0 || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            $display("FAIL rstmid_now cnt=%0d we=%b alu_rdy=%b mem_rdy=%b exp 0", count, rf_write_enable, alu_ready, mem_ready);
            bad++;
        end
        total++;
        if (pending_mask !== 8'h00 || rf_dest !== '0 || rf_data !== '0) begin
            $display("FAIL rstmid_outs mask=%h dest=%0d data=%h exp 0", pending_mask, rf_dest, rf_data);
            bad++;
        end
        step();
        step();
        total++;
        if (count !== 3'd0) begin
            $display("FAIL rstmid_hold cnt=%0d exp 0", count);
            bad++;
        end
        alu_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (mem_ready !== 1'b1) begin
            $display("FAIL rstmid_release mem_rdy=%b exp 1", mem_ready);
            bad++;
        end
        step();
        mem_valid = 1'b0;
        total++;
        if (count !== 3'd1 || rf_dest !== 3'd7) begin
            $display("FAIL rstmid_first_push cnt=%0d dest=%0d exp 1/7", count, rf_dest);
            bad++;
        end
        step();
        step();
        total++;
        if (wr_log.size() != 1 || wr_log[0] !== {3'd7, 32'h0000_0077}) begin
            $display("FAIL rstmid_log n=%0d first=%h exp 1/%h", wr_log.size(), wr_log[0], {3'd7, 32'h0000_0077});
            bad++;
        end
    endtask

    task automatic test_stream();
        wr_log.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            alu_valid = 1'b1;
            alu_dest  = 3'(i % 8);
            alu_data  = 32'h1000_0000 + 32'(i * 3);
            exp_q.push_back({3'(i % 8), 32'h1000_0000 + 32'(i * 3)});
            #1;
            total++;
            if (alu_ready !== 1'b1) begin
                $display("FAIL stream_ready i=%0d alu_rdy=%b exp 1", i, alu_ready);
                bad++;
            end
            step();
            total++;
            if (count !== 3'd1) begin
                $display("FAIL stream_count i=%0d cnt=%0d exp 1", i, count);
                bad++;
            end
        end
        alu_valid = 1'b0;
        step();
        step();
        total++;
        if (count !== 3'd0 || wr_log.size() != exp_q.size()) begin
            $display("FAIL stream_drain cnt=%0d n=%0d exp 0/%0d", count, wr_log.size(), exp_q.size());
            bad++;
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (wr_log[i] !== exp_q[i]) begin
                    $display("FAIL stream_order idx=%0d got=%h exp=%h", i, wr_log[i], exp_q[i]);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_waw();
        test_reset_mid();
        test_stream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
